// File: rtl/gs_div_if.sv
// Operand/result handshake bundle for the Goldschmidt divider sequencer.
// The abort line exists only when GS_DIV_ABORT_EN is defined.
interface gs_div_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef GS_DIV_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] quotient;

    modport master (
        output start,
        output dividend,
        output divisor,
`ifdef GS_DIV_ABORT_EN
        output abort,
`endif
        input  busy,
        input  done,
        input  err,
        input  quotient
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
`ifdef GS_DIV_ABORT_EN
        input  abort,
`endif
        output busy,
        output done,
        output err,
        output quotient
    );
endinterface

// File: rtl/gs_div_ctrl.sv
// Goldschmidt divider sequencer: seed lookup from an external ROM, then ITERS
// iterations on one shared multiplier. Optional abort input: GS_DIV_ABORT_EN.
module gs_div_ctrl #(
    parameter int WIDTH = 16,
    parameter int ITERS = 3
) (
    input  logic       clk,
    input  logic       rst,
    gs_div_if.slave    bus,
    output logic [2:0] rom_addr,
    input  logic [2:0] rom_data
);
    localparam int FRAC = WIDTH - 2;
    localparam int CW   = (ITERS < 1) ? 1 : $clog2(ITERS + 1);
    localparam logic [CW-1:0]    LAST_ITER = CW'(ITERS - 1);
    localparam logic [WIDTH-1:0] TWO_Q     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MUL_N,
        S_MUL_D,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_f;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [WIDTH-1:0]   w_mul_a;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_p;
    logic [WIDTH-1:0]   w_f_next;
    logic [WIDTH-1:0]   w_seed;
    logic               w_norm;
    logic               w_abort;

    // Single multiplier: n*f in MUL_N, d*f otherwise.
    assign w_mul_a  = (r_state == S_MUL_N) ? r_n : r_d;
    assign w_prod   = {{WIDTH{1'b0}}, w_mul_a} * {{WIDTH{1'b0}}, r_f};
    assign w_p      = w_prod[FRAC +: WIDTH];
    assign w_f_next = TWO_Q - w_p;

    // Seed factor 0.5 + rom_data/16 in Q2.FRAC.
    assign w_seed   = (WIDTH'(1) << (FRAC - 1)) | (WIDTH'(rom_data) << (FRAC - 4));
    assign w_norm   = (bus.divisor[WIDTH-1:WIDTH-2] == 2'b01);

`ifdef GS_DIV_ABORT_EN
    assign w_abort  = bus.abort &&
                      ((r_state == S_LOOKUP) || (r_state == S_MUL_N) || (r_state == S_MUL_D));
`else
    assign w_abort  = 1'b0;
`endif

    assign rom_addr     = r_d[FRAC-1:FRAC-3];
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.quotient = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_d     <= '0;
            r_f     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_abort) begin
            // Drop the operation in flight; quotient and err keep their values.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (w_norm) begin
                            r_n     <= bus.dividend;
                            r_d     <= bus.divisor;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                            r_state <= S_LOOKUP;
                        end else begin
                            r_err   <= 1'b1;
                            r_q     <= {WIDTH{1'b1}};
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_LOOKUP: begin
                    r_f     <= w_seed;
                    r_state <= S_MUL_N;
                end
                S_MUL_N: begin
                    r_n     <= w_p;
                    r_state <= S_MUL_D;
                end
                S_MUL_D: begin
                    r_d   <= w_p;
                    r_f   <= w_f_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        // r_n already holds this iteration's numerator.
                        r_q     <= r_n;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_MUL_N;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gs_div_ctrl.sv
// Self-checking bench for gs_div_ctrl: directed scenarios plus random operands
// checked against an arithmetic Goldschmidt model.
module tb_gs_div_ctrl;
    localparam int WIN = 14;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    gs_div_if #(.WIDTH(16)) bus0 ();
    gs_div_if #(.WIDTH(16)) bus1 ();

    logic [2:0] rom_addr0, rom_data0, rom_addr1, rom_data1;
    logic       rom_tbl;
    logic [2:0] tbl [0:7];

    assign rom_data0 = rom_tbl ? tbl[rom_addr0] : 3'd7;
    assign rom_data1 = 3'd7;

    gs_div_ctrl #(.WIDTH(16), .ITERS(3)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .rom_addr(rom_addr0), .rom_data(rom_data0));
    gs_div_ctrl #(.WIDTH(16), .ITERS(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .rom_addr(rom_addr1), .rom_data(rom_data1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        busy_log [0:WIN];
    logic        done_log [0:WIN];
    logic        err_log  [0:WIN];
    logic [15:0] q_log    [0:WIN];
    logic [2:0]  addr_log [0:WIN];
    int          done_cnt;
    int          done_first;

    // Reference: Goldschmidt in plain integer arithmetic on Q2.14 values.
    function automatic logic [16:0] model_div(input logic [15:0] dvd, input logic [15:0] dvs,
                                              input int iters, input logic use_tbl);
        longint n, d, f, p;
        logic [2:0] seed;
        if (dvs[15:14] != 2'b01) return {1'b1, 16'hFFFF};
        seed = use_tbl ? tbl[dvs[13:11]] : 3'd7;
        f = 64'd8192 + longint'(seed) * 1024;
        n = longint'(dvd);
        d = longint'(dvs);
        for (int i = 0; i < iters; i++) begin
            n = ((n * f) >> 14) & 64'hFFFF;
            p = ((d * f) >> 14) & 64'hFFFF;
            d = p;
            f = (64'd32768 - p) & 64'hFFFF;
        end
        return {1'b0, n[15:0]};
    endfunction

    // One start on dut0, logging outputs for WIN cycles; optional disturbances at cycle k.
    task automatic run_op(input logic [15:0] dvd, input logic [15:0] dvs,
                          input int rst_k, input int abort_k, input int restart_k);
        @(negedge clk);
        rst = 1'b0;
        busy_log[0] = bus0.busy;
        q_log[0]    = bus0.quotient;
        err_log[0]  = bus0.err;
        bus0.start    = 1'b1;
        bus0.dividend = dvd;
        bus0.divisor  = dvs;
        done_cnt   = 0;
        done_first = -1;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            bus0.start = 1'b0;
            rst = 1'b0;
`ifdef GS_DIV_ABORT_EN
            bus0.abort = 1'b0;
`endif
            busy_log[k] = bus0.busy;
            done_log[k] = bus0.done;
            err_log[k]  = bus0.err;
            q_log[k]    = bus0.quotient;
            addr_log[k] = rom_addr0;
            if (bus0.done) begin
                done_cnt++;
                if (done_first < 0) done_first = k;
            end
            if (k == rst_k) rst = 1'b1;
`ifdef GS_DIV_ABORT_EN
            if (k == abort_k) bus0.abort = 1'b1;
`endif
            if (k == restart_k) begin
                bus0.start    = 1'b1;
                bus0.dividend = ~dvd;
                bus0.divisor  = 16'h4800;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp += 6;
        if (bus0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        if (bus0.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", bus0.done); end
        if (bus0.err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", bus0.err); end
        if (bus0.quotient !== 16'h0) begin n_bad++; $display("FAIL reset_quotient: got %h expected 0000", bus0.quotient); end
        if (rom_addr0 !== 3'd0) begin n_bad++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr0); end
        if (bus1.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy1: got %b expected 0", bus1.busy); end
        rst = 1'b0;
        $display("reset: busy=%b done=%b err=%b q=%h", bus0.busy, bus0.done, bus0.err, bus0.quotient);
    endtask

    task automatic test_basic();
        int busy_bad;
        rom_tbl = 1'b0;
        run_op(16'h4000, 16'h4000, -1, -1, -1);
        busy_bad = 0;
        for (int k = 0; k <= WIN; k++)
            if (busy_log[k] !== ((k >= 1) && (k <= 8))) busy_bad++;
        n_cmp += 6;
        if (addr_log[1] !== 3'd0) begin n_bad++; $display("FAIL basic_rom_addr: got %0d expected 0", addr_log[1]); end
        if (done_first != 8) begin n_bad++; $display("FAIL basic_latency: got %0d expected 8", done_first); end
        if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
        if (q_log[8] !== 16'h3FFF) begin n_bad++; $display("FAIL basic_quotient: got %h expected 3fff", q_log[8]); end
        if (err_log[8] !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", err_log[8]); end
        if (busy_bad != 0) begin n_bad++; $display("FAIL basic_busy_window: got %0d bad cycles expected 0", busy_bad); end
        $display("basic: 4000/4000 done@%0d q=%h", done_first, q_log[8]);
    endtask

    task automatic test_iters1();
        int first;
        logic [15:0] q;
        first = -1;
        q = '0;
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.dividend = 16'h6000;
        bus1.divisor  = 16'h4000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus1.start = 1'b0;
            if (bus1.done && first < 0) begin first = k; q = bus1.quotient; end
        end
        n_cmp += 2;
        if (first != 4) begin n_bad++; $display("FAIL iters1_latency: got %0d expected 4", first); end
        if (q !== 16'h5A00) begin n_bad++; $display("FAIL iters1_quotient: got %h expected 5a00", q); end
        $display("iters1: 6000/4000 done@%0d q=%h", first, q);
    endtask

    task automatic test_invalid();
        int busy_bad;
        run_op(16'h1234, 16'h2000, -1, -1, -1);
        busy_bad = 0;
        for (int k = 0; k <= WIN; k++)
            if (busy_log[k] !== (k == 1)) busy_bad++;
        n_cmp += 5;
        if (done_first != 1) begin n_bad++; $display("FAIL invalid_latency: got %0d expected 1", done_first); end
        if (done_cnt != 1) begin n_bad++; $display("FAIL invalid_done_count: got %0d expected 1", done_cnt); end
        if (err_log[1] !== 1'b1) begin n_bad++; $display("FAIL invalid_err: got %b expected 1", err_log[1]); end
        if (q_log[1] !== 16'hFFFF) begin n_bad++; $display("FAIL invalid_quotient: got %h expected ffff", q_log[1]); end
        if (busy_bad != 0) begin n_bad++; $display("FAIL invalid_busy_window: got %0d bad cycles expected 0", busy_bad); end
        $display("invalid: divisor=2000 done@%0d err=%b q=%h", done_first, err_log[1], q_log[1]);
    endtask

    task automatic test_start_ignored();
        run_op(16'h4000, 16'h4000, -1, -1, 3);
        n_cmp += 4;
        if (done_first != 8) begin n_bad++; $display("FAIL ignored_latency: got %0d expected 8", done_first); end
        if (done_cnt != 1) begin n_bad++; $display("FAIL ignored_done_count: got %0d expected 1", done_cnt); end
        if (q_log[8] !== 16'h3FFF) begin n_bad++; $display("FAIL ignored_quotient: got %h expected 3fff", q_log[8]); end
        if (q_log[WIN] !== 16'h3FFF) begin n_bad++; $display("FAIL ignored_quotient_held: got %h expected 3fff", q_log[WIN]); end
        $display("start_ignored: done@%0d count=%0d q=%h", done_first, done_cnt, q_log[8]);
    endtask

    task automatic test_rst_mid();
        run_op(16'h4000, 16'h4000, 4, -1, -1);
        n_cmp += 3;
        if (busy_log[5] !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy_log[5]); end
        if (q_log[5] !== 16'h0) begin n_bad++; $display("FAIL rst_mid_quotient: got %h expected 0000", q_log[5]); end
        if (done_cnt != 0) begin n_bad++; $display("FAIL rst_mid_done_count: got %0d expected 0", done_cnt); end
        $display("rst_mid: busy@5=%b q@5=%h dones=%0d", busy_log[5], q_log[5], done_cnt);
        run_op(16'h4000, 16'h4000, -1, -1, -1);
        n_cmp += 2;
        if (done_first != 8) begin n_bad++; $display("FAIL rst_mid_restart_latency: got %0d expected 8", done_first); end
        if (q_log[8] !== 16'h3FFF) begin n_bad++; $display("FAIL rst_mid_restart_quotient: got %h expected 3fff", q_log[8]); end
        $display("rst_mid restart: done@%0d q=%h", done_first, q_log[8]);
    endtask

`ifdef GS_DIV_ABORT_EN
    task automatic test_abort();
        logic [15:0] prev_q;
        logic        prev_err;
        run_op(16'h5000, 16'h4000, -1, 3, -1);
        prev_q   = q_log[0];
        prev_err = err_log[0];
        n_cmp += 4;
        if (busy_log[4] !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy_log[4]); end
        if (q_log[4] !== prev_q) begin n_bad++; $display("FAIL abort_quotient: got %h expected %h", q_log[4], prev_q); end
        if (err_log[4] !== prev_err) begin n_bad++; $display("FAIL abort_err: got %b expected %b", err_log[4], prev_err); end
        if (done_cnt != 0) begin n_bad++; $display("FAIL abort_done_count: got %0d expected 0", done_cnt); end
        $display("abort: busy@4=%b q@4=%h dones=%0d", busy_log[4], q_log[4], done_cnt);
        run_op(16'h4000, 16'h4000, -1, -1, -1);
        n_cmp += 2;
        if (done_first != 8) begin n_bad++; $display("FAIL abort_restart_latency: got %0d expected 8", done_first); end
        if (q_log[8] !== 16'h3FFF) begin n_bad++; $display("FAIL abort_restart_quotient: got %h expected 3fff", q_log[8]); end
        $display("abort restart: done@%0d q=%h", done_first, q_log[8]);
    endtask
`endif

    task automatic test_random();
        logic [15:0] dvd, dvs;
        logic [16:0] exp;
        int          lat;
        rom_tbl = 1'b1;
        for (int i = 0; i < 30; i++) begin
            dvd = 16'($urandom);
            if ($urandom_range(0, 4) == 0) dvs = 16'($urandom);
            else dvs = {2'b01, 14'($urandom)};
            exp = model_div(dvd, dvs, 3, 1'b1);
            lat = exp[16] ? 1 : 8;
            run_op(dvd, dvs, -1, -1, -1);
            n_cmp += 2;
            if (done_first != lat || done_cnt != 1) begin
                n_bad++;
                $display("FAIL rand_latency[%0d]: got done@%0d count %0d expected done@%0d count 1", i, done_first, done_cnt, lat);
            end
            if (done_first < 1 || {err_log[lat], q_log[lat]} !== exp) begin
                n_bad++;
                $display("FAIL rand_result[%0d]: %h/%h got err=%b q=%h expected err=%b q=%h", i, dvd, dvs, err_log[lat], q_log[lat], exp[16], exp[15:0]);
            end
            $display("random[%0d]: %h/%h done@%0d err=%b q=%h", i, dvd, dvs, done_first, err_log[lat], q_log[lat]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0] = 3'd7; tbl[1] = 3'd5; tbl[2] = 3'd4; tbl[3] = 3'd3;
        tbl[4] = 3'd2; tbl[5] = 3'd1; tbl[6] = 3'd1; tbl[7] = 3'd0;
        rom_tbl = 1'b0;
        rst = 1'b1;
        bus0.start = 1'b0; bus0.dividend = '0; bus0.divisor = '0;
        bus1.start = 1'b0; bus1.dividend = '0; bus1.divisor = '0;
`ifdef GS_DIV_ABORT_EN
        bus0.abort = 1'b0;
        bus1.abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_iters1();
        test_invalid();
        test_start_ignored();
        test_rst_mid();
`ifdef GS_DIV_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
